// File: rtl/redmule_x_scheduler.sv
// rtl/redmule_x_scheduler.sv - X buffer load/shift scheduler for the RedMulE engine
//
// Purpose: sequences the X buffer for a job of n_blocks column blocks. Each
// block is filled from the streamer, beat by beat, then drained by the engine.
// A drain is H horizontal shifts followed by one depth shift, repeated once per
// depth slot.
//
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync soft clear)
//   start_i, n_blocks_i, rows_lftovr_i, cols_lftovr_i, slots_i : job configuration
//   x_valid_i / x_ready_o : streamer beat handshake
//   consume_i             : engine request to drain the ready block
//   full_i                : X buffer full flag, used only for error checking
//   load_o, h_shift_o, d_shift_o : X buffer control strobes
//   busy_o, blk_ready_o, done_o, err_o : status
module redmule_x_scheduler #(
  parameter int H = 4,
  parameter int W = 12,
  parameter int D = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [15:0]          n_blocks_i,
  input  logic [$clog2(W):0]   rows_lftovr_i,
  input  logic [$clog2(H):0]   cols_lftovr_i,
  input  logic [$clog2(D):0]   slots_i,
  input  logic                 x_valid_i,
  output logic                 x_ready_o,
  input  logic                 consume_i,
  input  logic                 full_i,
  output logic                 load_o,
  output logic                 h_shift_o,
  output logic                 d_shift_o,
  output logic                 busy_o,
  output logic                 blk_ready_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int MAXB = (W + H - 1) / H;
  localparam int BW   = $clog2(MAXB + 1);
  localparam int LW   = $clog2(D * MAXB + 1);
  localparam int HW   = $clog2(H + 1);
  localparam int DW   = $clog2(D + 1);
  localparam int SW   = $clog2(D) + 1;

  typedef enum logic [2:0] {IDLE, FILL, READY, HSHIFT, DSHIFT, DONE} state_t;

  state_t          state;
  logic [15:0]     n_blocks_q;
  logic [BW-1:0]   beats_q;
  logic            cols_nz_q;
  logic [SW-1:0]   slots_q;
  logic [LW-1:0]   beat_cnt;
  logic [HW-1:0]   h_cnt;
  logic [DW-1:0]   d_cnt;
  logic [15:0]     blk_cnt;
  logic            err_q;

  logic [31:0]     w_limit;
  logic [BW-1:0]   beats_c;
  logic [15:0]     blk_next;
  logic            last_blk;
  logic [SW-1:0]   tgt_slots;
  logic [LW-1:0]   tgt_loads;

  // Out-of-range row/slot leftovers fall back to the full size so the
  // counters can never be asked to reach a value they cannot hold.
  always_comb begin
    w_limit = 32'(W);
    if (rows_lftovr_i != '0 && 32'(rows_lftovr_i) <= 32'(W))
      w_limit = 32'(rows_lftovr_i);
    beats_c = BW'((w_limit + 32'(H) - 32'd1) / 32'(H));
  end

  always_comb begin
    blk_next  = blk_cnt + 16'd1;
    last_blk  = (blk_next == n_blocks_q);
    tgt_slots = (last_blk && cols_nz_q) ? slots_q : SW'(D);
    tgt_loads = LW'(32'(tgt_slots) * 32'(beats_q));
  end

  // All outputs decode the state register, so reset drives them low at once.
  assign x_ready_o   = (state == FILL);
  assign load_o      = x_valid_i & x_ready_o;
  assign h_shift_o   = (state == HSHIFT);
  assign d_shift_o   = (state == DSHIFT);
  assign blk_ready_o = (state == READY);
  assign done_o      = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign err_o       = err_q;

  // Configuration is only meaningful outside IDLE, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && start_i) begin
      n_blocks_q <= n_blocks_i;
      beats_q    <= beats_c;
      cols_nz_q  <= (cols_lftovr_i != '0);
      slots_q    <= (slots_i == '0 || slots_i > SW'(D)) ? SW'(D) : slots_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
      h_cnt    <= '0;
      d_cnt    <= '0;
      blk_cnt  <= '0;
      err_q    <= 1'b0;
    end else if (clear_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
      h_cnt    <= '0;
      d_cnt    <= '0;
      blk_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((load_o && full_i) || (consume_i && state != READY))
        err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (start_i) begin
            beat_cnt <= '0;
            h_cnt    <= '0;
            d_cnt    <= '0;
            blk_cnt  <= '0;
            state    <= (n_blocks_i != 16'd0) ? FILL : DONE;
          end
        end
        FILL: begin
          if (load_o) begin
            beat_cnt <= beat_cnt + LW'(1);
            if (beat_cnt + LW'(1) == tgt_loads)
              state <= READY;
          end
        end
        READY: begin
          if (consume_i) begin
            h_cnt <= '0;
            state <= HSHIFT;
          end
        end
        HSHIFT: begin
          if (h_cnt == HW'(H - 1)) begin
            h_cnt <= '0;
            state <= DSHIFT;
          end else begin
            h_cnt <= h_cnt + HW'(1);
          end
        end
        DSHIFT: begin
          d_cnt <= d_cnt + DW'(1);
          if (32'(d_cnt) + 32'd1 < 32'(tgt_slots)) begin
            state <= HSHIFT;
          end else begin
            blk_cnt <= blk_next;
            if (last_blk) begin
              state <= DONE;
            end else begin
              beat_cnt <= '0;
              d_cnt    <= '0;
              h_cnt    <= '0;
              state    <= FILL;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redmule_x_scheduler.sv
// tb/tb_redmule_x_scheduler.sv - table-driven bench for redmule_x_scheduler
module tb_redmule_x_scheduler;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] n_blocks_i = '0;
  logic [4:0]  rows_lftovr_i = '0;
  logic [2:0]  cols_lftovr_i = '0;
  logic [1:0]  slots_i = '0;
  logic        x_valid_i = 1'b0;
  logic        consume_i = 1'b0;
  logic        full_i = 1'b0;
  logic        x_ready_o, load_o, h_shift_o, d_shift_o;
  logic        busy_o, blk_ready_o, done_o, err_o;

  redmule_x_scheduler #(.H(4), .W(12), .D(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .n_blocks_i(n_blocks_i), .rows_lftovr_i(rows_lftovr_i),
    .cols_lftovr_i(cols_lftovr_i), .slots_i(slots_i),
    .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .consume_i(consume_i),
    .full_i(full_i), .load_o(load_o), .h_shift_o(h_shift_o),
    .d_shift_o(d_shift_o), .busy_o(busy_o), .blk_ready_o(blk_ready_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // inputs: {clear, start, x_valid, consume, full}
  localparam logic [4:0] I0 = 5'b00000;
  localparam logic [4:0] IC = 5'b10000;
  localparam logic [4:0] IS = 5'b01000;
  localparam logic [4:0] IV = 5'b00100;
  localparam logic [4:0] IK = 5'b00010;
  localparam logic [4:0] IF = 5'b00001;
  // outputs: {load, x_ready, h_shift, d_shift, blk_ready, done, busy, err}
  localparam logic [7:0] E_IDLE = 8'b0000_0000;
  localparam logic [7:0] E_LOAD = 8'b1100_0010;
  localparam logic [7:0] E_WAIT = 8'b0100_0010;
  localparam logic [7:0] E_RDY  = 8'b0000_1010;
  localparam logic [7:0] E_H    = 8'b0010_0010;
  localparam logic [7:0] E_D    = 8'b0001_0010;
  localparam logic [7:0] E_DONE = 8'b0000_0110;
  localparam logic [7:0] E_ERR  = 8'b0000_0001;

  typedef struct {
    string      name;
    logic [4:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_miss = 0;

  function automatic logic [7:0] outs();
    return {load_o, x_ready_o, h_shift_o, d_shift_o, blk_ready_o, done_o, busy_o, err_o};
  endfunction

  task automatic add(input string nm, input int n, input logic [4:0] in, input logic [7:0] ex);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.name = nm;
      v.in   = in;
      v.exp  = ex;
      tbl.push_back(v);
    end
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_miss++;
      $display("FAIL %s: outputs %b, expected %b", nm, act, ex);
    end
  endtask

  task automatic run();
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      {clear_i, start_i, x_valid_i, consume_i, full_i} = tbl[i].in;
      @(negedge clk);
      check($sformatf("%s[%0d]", tbl[i].name, i), outs(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  task automatic cfg(input logic [15:0] nb, input logic [4:0] rows,
                     input logic [2:0] cols, input logic [1:0] sl);
    n_blocks_i    = nb;
    rows_lftovr_i = rows;
    cols_lftovr_i = cols;
    slots_i       = sl;
  endtask

  task automatic job_full();
    cfg(16'd1, 5'd0, 3'd0, 2'd0);
    add("A_start", 1, IS, E_IDLE);
    add("A_load",  5, IV, E_LOAD);
    add("A_load6", 1, IV | IS, E_LOAD);
    add("A_rdy",   1, IK, E_RDY);
    add("A_h",     2, I0, E_H);
    add("A_hst",   1, IS, E_H);
    add("A_h",     1, I0, E_H);
    add("A_d",     1, I0, E_D);
    add("A_h",     4, I0, E_H);
    add("A_d",     1, I0, E_D);
    add("A_done",  1, I0, E_DONE);
    add("A_idle",  1, I0, E_IDLE);
    run();
  endtask

  initial begin
    #3;
    check("reset", outs(), E_IDLE);
    @(negedge clk);
    rst_i = 1'b0;

    job_full();

    // 5 valid rows -> 2 beats per slot, 4 loads; x_valid toggles
    cfg(16'd1, 5'd5, 3'd0, 2'd0);
    add("B_start", 1, IS, E_IDLE);
    for (int i = 0; i < 3; i++) begin
      add("B_load", 1, IV, E_LOAD);
      add("B_wait", 1, I0, E_WAIT);
    end
    add("B_load",  1, IV, E_LOAD);
    add("B_hold",  2, I0, E_RDY);
    add("B_rdy",   1, IK, E_RDY);
    add("B_h",     4, I0, E_H);
    add("B_d",     1, I0, E_D);
    add("B_h",     4, I0, E_H);
    add("B_d",     1, I0, E_D);
    add("B_done",  1, I0, E_DONE);
    add("B_idle",  1, I0, E_IDLE);
    run();

    // two blocks, partial last block of one slot
    cfg(16'd2, 5'd0, 3'd2, 2'd1);
    add("C_start", 1, IS, E_IDLE);
    add("C_load0", 6, IV, E_LOAD);
    add("C_rdy0",  1, IK, E_RDY);
    add("C_h0",    4, I0, E_H);
    add("C_d0",    1, I0, E_D);
    add("C_h0",    4, I0, E_H);
    add("C_d0",    1, I0, E_D);
    add("C_load1", 3, IV, E_LOAD);
    add("C_rdy1",  1, IK, E_RDY);
    add("C_h1",    4, I0, E_H);
    add("C_d1",    1, I0, E_D);
    add("C_done",  1, I0, E_DONE);
    add("C_idle",  1, I0, E_IDLE);
    run();

    // empty job
    cfg(16'd0, 5'd0, 3'd0, 2'd0);
    add("D_start", 1, IS, E_IDLE);
    add("D_done",  1, IV, E_DONE);
    add("D_idle",  1, I0, E_IDLE);
    run();

    // consume during FILL sets a sticky error; clear removes it
    cfg(16'd1, 5'd0, 3'd0, 2'd0);
    add("E_start", 1, IS, E_IDLE);
    add("E_cons",  1, IV | IK, E_LOAD);
    add("E_stick", 1, IV, E_LOAD | E_ERR);
    add("E_clr",   1, IV | IC, E_LOAD | E_ERR);
    add("E_idle",  1, I0, E_IDLE);
    // load while the buffer reports full
    add("F_start", 1, IS, E_IDLE);
    add("F_full",  1, IV | IF, E_LOAD);
    add("F_stick", 1, I0, E_WAIT | E_ERR);
    add("F_clr",   1, IC, E_WAIT | E_ERR);
    add("F_idle",  1, I0, E_IDLE);
    run();

    // asynchronous reset in the middle of a drain
    cfg(16'd1, 5'd0, 3'd0, 2'd0);
    add("G_start", 1, IS, E_IDLE);
    add("G_load",  6, IV, E_LOAD);
    add("G_rdy",   1, IK, E_RDY);
    add("G_h",     2, I0, E_H);
    run();
    rst_i = 1'b1;
    #1;
    check("G_async_rst", outs(), E_IDLE);
    @(posedge clk);
    #1;
    check("G_rst_hold", outs(), E_IDLE);
    rst_i = 1'b0;
    job_full();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/redmule_x_scheduler.md
REDMULE_X_SCHEDULER -- requirements
Module: redmule_x_scheduler

Interface
REQ-001 SHALL have parameter H, default 4 (ARRAY_HEIGHT), meaning PEs per row and rows loaded per beat.
REQ-002 SHALL have parameter W, default 12 (ARRAY_WIDTH), meaning parallel rows held by the X buffer.
REQ-003 SHALL have parameter D, default 2, meaning X buffer depth slots per block.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port clear_i  input  1  synchronous soft clear, same effect as reset.
REQ-007 SHALL have port start_i  input  1  one-cycle pulse that latches configuration and starts a job.
REQ-008 SHALL have port n_blocks_i  input  16  X column blocks in the job; 0 means an empty job.
REQ-009 SHALL have port rows_lftovr_i  input  $clog2(W)+1  valid rows when not W; 0 means W.
REQ-010 SHALL have port cols_lftovr_i  input  $clog2(H)+1  nonzero marks a partial last block.
REQ-011 SHALL have port slots_i  input  $clog2(D)+1  depth slots (1..D) of the partial last block.
REQ-012 SHALL have port x_valid_i / x_ready_o  input / output  1 / 1  streamer beat handshake.
REQ-013 SHALL have port consume_i  input  1  engine pulse requesting the next block drain.
REQ-014 SHALL have port full_i  input  1  X buffer full flag, used for checking only.
REQ-015 SHALL have port load_o, h_shift_o, d_shift_o  output  1 each  X buffer control strobes.
REQ-016 SHALL have port busy_o, blk_ready_o, done_o, err_o  output  1 each  status.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, READY, HSHIFT, DSHIFT, DONE; reset state IDLE.
REQ-018 IDLE: start_i with n_blocks_i!=0 -> FILL; with n_blocks_i==0 -> DONE; configuration latched on start_i only.
REQ-019 Beats per slot SHALL be ceil(w_limit/H), where w_limit = rows_lftovr ? rows_lftovr : W.
REQ-020 Target slots SHALL be slots_i on the last block when cols_lftovr!=0, otherwise D.
REQ-021 FILL: x_ready_o=1; load_o = x_valid_i & x_ready_o, combinational in the same cycle; each load increments beat_cnt.
REQ-022 When the load completing slots*beats is accepted, the FSM SHALL go to READY next cycle with x_ready_o=0.
REQ-023 READY: blk_ready_o=1; consume_i -> HSHIFT next cycle; the FSM SHALL otherwise hold indefinitely.
REQ-024 HSHIFT: h_shift_o=1 for exactly H consecutive cycles (h_cnt 0..H-1), then -> DSHIFT.
REQ-025 DSHIFT: d_shift_o=1 for one cycle; d_cnt increments; if d_cnt+1 < target slots -> HSHIFT, else block complete.
REQ-026 On block complete, blk_cnt SHALL increment; if blk_cnt+1 == n_blocks -> DONE, else -> FILL with beat_cnt, d_cnt, h_cnt zeroed.
REQ-027 DONE: done_o=1 for exactly one cycle, then -> IDLE.
REQ-028 busy_o SHALL be 1 in every state except IDLE.
REQ-029 start_i outside IDLE SHALL be ignored.
REQ-030 err_o SHALL be sticky; it is set when load_o=1 while full_i=1, or when consume_i=1 outside READY.
REQ-031 load_o, h_shift_o and d_shift_o SHALL be mutually exclusive in every cycle.
REQ-032 Counters SHALL be sized for maximum values without wrap; blk_cnt SHALL be 16 bits.

Reset
REQ-033 rst_i or clear_i SHALL force state IDLE, clear all counters and err_o, and drive every output 0, including mid-job.
REQ-034 Only the latched configuration SHALL be exempt from clearing, and it is unused in IDLE.

Verification
REQ-035 H=4,W=12,D=2; start n_blocks=1, rows_lftovr=0, x_valid held 1 -> 6 load_o cycles, blk_ready_o next cycle; consume -> h_shift×4, d_shift, h_shift×4, d_shift, done_o pulse.
REQ-036 rows_lftovr=5 -> 2 beats/slot, READY after 4 loads; x_valid toggling 1/0 -> loads only on valid cycles.
REQ-037 n_blocks=2, cols_lftovr=2, slots=1 -> block 0 drains 2 d_shift; block 1 loads 3 beats, drains 1 d_shift, done_o.
REQ-038 start with n_blocks=0 -> DONE next cycle, done_o single pulse, no strobes.
REQ-039 rst_i asserted mid-HSHIFT -> outputs 0 asynchronously, IDLE; a new start_i then runs a clean job.
REQ-040 consume_i during FILL -> err_o=1 sticky; full_i=1 during a load -> err_o=1; clear_i -> err_o=0.
